wash_sequencer: RTL and testbench

Parametrised wash-cycle controller for the washing machine. It sequences fill, wash, a configurable number of rinse passes, drain and spin, then sounds an end-of-cycle alarm. It keeps a per-phase BCD countdown that feeds the existing dynamic-scan and seven-segment path, and it supports pause/resume. It sits between the button inputs and the display path, and is clocked from the system clock with a 1 Hz enable from the prescaler chain.

---
 rtl/wash_pkg.sv | 28 ++
 rtl/wash_sequencer_bcd.sv | 53 +++++
 rtl/wash_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared definitions for the wash-cycle sequencer: state codes and widths.
// Optional fill timeout is enabled by defining WASH_FILL_TIMEOUT_EN.
package wash_pkg;

  localparam int STATE_W = 3;
  localparam int BCD_W   = 4;

  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] FILL  = 3'd1;
  localparam logic [STATE_W-1:0] WASH  = 3'd2;
  localparam logic [STATE_W-1:0] DRAIN = 3'd3;
  localparam logic [STATE_W-1:0] SPIN  = 3'd4;
  localparam logic [STATE_W-1:0] DONE  = 3'd5;
  localparam logic [STATE_W-1:0] PAUSE = 3'd6;
  localparam logic [STATE_W-1:0] ERROR = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = IDLE,
    S_FILL  = FILL,
    S_WASH  = WASH,
    S_DRAIN = DRAIN,
    S_SPIN  = SPIN,
    S_DONE  = DONE,
    S_PAUSE = PAUSE,
    S_ERROR = ERROR
  } state_e;

endpackage

// File: rtl/wash_sequencer_bcd.sv
// Multi-digit BCD down counter with load priority and cascaded borrow.
// Holds its value whenever neither load nor dec is asserted.
module bcd_down_counter
  import wash_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    dec,
  output logic [BCD_W*DIGITS-1:0] value,
  output logic                    is_one
);

  logic [BCD_W*DIGITS-1:0] r_val;
  logic [BCD_W*DIGITS-1:0] w_dec_val;

  // Decrement by one: each digit borrows only if all lower digits were 0.
  always_comb begin
    logic       v_borrow;
    logic [3:0] v_dig;
    v_borrow  = 1'b1;
    w_dec_val = r_val;
    for (int i = 0; i < DIGITS; i++) begin
      v_dig = r_val[BCD_W*i +: BCD_W];
      if (v_borrow) begin
        if (v_dig == 4'd0) begin
          w_dec_val[BCD_W*i +: BCD_W] = 4'd9;
        end else begin
          w_dec_val[BCD_W*i +: BCD_W] = v_dig - 4'd1;
          v_borrow = 1'b0;
        end
      end
    end
  end

  // Value register: load wins over decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val <= '0;
    end else if (load) begin
      r_val <= load_val;
    end else if (dec) begin
      r_val <= w_dec_val;
    end
  end

  assign value  = r_val;
  assign is_one = (r_val == {{(BCD_W*DIGITS-1){1'b0}}, 1'b1});

endmodule

// File: rtl/wash_sequencer.sv
// Wash-cycle sequencer: fill, wash, rinse passes, drain, spin, alarm.
// Define WASH_FILL_TIMEOUT_EN to add a fill timeout leading to ERROR.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int WASH_SEC         = 30,
  parameter int RINSE_SEC        = 20,
  parameter int DRAIN_SEC        = 10,
  parameter int SPIN_SEC         = 15,
  parameter int ALARM_SEC        = 5,
  parameter int RINSE_CNT        = 2,
  parameter int TIME_DIGITS      = 4,
  parameter int FILL_TIMEOUT_SEC = 60
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         waterfull,
  output logic                         fill_valve,
  output logic                         motor,
  output logic                         drain_valve,
  output logic                         alarm,
  output logic [STATE_W-1:0]           state,
  output logic [3:0]                   pass_idx,
  output logic [BCD_W*TIME_DIGITS-1:0] time_bcd
);

  localparam int TW = BCD_W * TIME_DIGITS;

  function automatic logic [TW-1:0] to_bcd(input int v);
    logic [TW-1:0] r;
    int            x;
    r = '0;
    x = v;
    for (int i = 0; i < TIME_DIGITS; i++) begin
      r[BCD_W*i +: BCD_W] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam logic [TW-1:0] L_WASH  = to_bcd(WASH_SEC);
  localparam logic [TW-1:0] L_RINSE = to_bcd(RINSE_SEC);
  localparam logic [TW-1:0] L_DRAIN = to_bcd(DRAIN_SEC);
  localparam logic [TW-1:0] L_SPIN  = to_bcd(SPIN_SEC);
  localparam logic [TW-1:0] L_ALARM = to_bcd(ALARM_SEC);
  localparam logic [3:0]    L_RC    = 4'(RINSE_CNT);
`ifdef WASH_FILL_TIMEOUT_EN
  localparam logic [TW-1:0] L_FILL  = to_bcd(FILL_TIMEOUT_SEC);
`else
  localparam logic [TW-1:0] L_FILL  = '0;
`endif

  state_e        r_state;
  state_e        r_saved;
  logic [3:0]    r_pass;
  logic          r_start_q;
  logic          r_stop_q;
  logic          r_start_edge;
  logic          r_stop_edge;

  state_e        w_next;
  state_e        w_saved_n;
  logic [3:0]    w_pass_n;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_dec;
  logic          w_expire;
  logic          w_is_one;
  logic [TW-1:0] w_time;

  bcd_down_counter #(
    .DIGITS(TIME_DIGITS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .value    (w_time),
    .is_one   (w_is_one)
  );

  assign w_expire = tick & w_is_one;

  // Button edge detection, registered so actions land one clk later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_q    <= 1'b0;
      r_stop_q     <= 1'b0;
      r_start_edge <= 1'b0;
      r_stop_edge  <= 1'b0;
    end else begin
      r_start_q    <= start;
      r_stop_q     <= stop;
      r_start_edge <= start & ~r_start_q;
      r_stop_edge  <= stop & ~r_stop_q;
    end
  end

  // State, saved state and pass index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_pass  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_saved <= w_saved_n;
      r_pass  <= w_pass_n;
    end
  end

  // Next state, timer load/decrement; stop edge outranks start edge.
  always_comb begin
    w_next     = r_state;
    w_saved_n  = r_saved;
    w_pass_n   = r_pass;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_stop_edge && r_start_edge) begin
          w_next     = S_FILL;
          w_pass_n   = 4'd0;
          w_load     = 1'b1;
          w_load_val = L_FILL;
        end
      end
      S_FILL: begin
        if (r_stop_edge) begin
          w_next    = S_PAUSE;
          w_saved_n = S_FILL;
        end else if (waterfull) begin
          w_next     = S_WASH;
          w_load     = 1'b1;
          w_load_val = (r_pass == 4'd0) ? L_WASH : L_RINSE;
`ifdef WASH_FILL_TIMEOUT_EN
        end else if (w_expire) begin
          w_next     = S_ERROR;
          w_load     = 1'b1;
          w_load_val = '0;
        end else begin
          w_dec = tick;
`endif
        end
      end
      S_WASH: begin
        if (r_stop_edge) begin
          w_next    = S_PAUSE;
          w_saved_n = S_WASH;
        end else if (w_expire) begin
          w_next     = S_DRAIN;
          w_load     = 1'b1;
          w_load_val = L_DRAIN;
        end else begin
          w_dec = tick;
        end
      end
      S_DRAIN: begin
        if (r_stop_edge) begin
          w_next    = S_PAUSE;
          w_saved_n = S_DRAIN;
        end else if (w_expire) begin
          w_load = 1'b1;
          if (r_pass < L_RC) begin
            w_next     = S_FILL;
            w_pass_n   = r_pass + 4'd1;
            w_load_val = L_FILL;
          end else begin
            w_next     = S_SPIN;
            w_load_val = L_SPIN;
          end
        end else begin
          w_dec = tick;
        end
      end
      S_SPIN: begin
        if (r_stop_edge) begin
          w_next    = S_PAUSE;
          w_saved_n = S_SPIN;
        end else if (w_expire) begin
          w_next     = S_DONE;
          w_load     = 1'b1;
          w_load_val = L_ALARM;
        end else begin
          w_dec = tick;
        end
      end
      S_DONE: begin
        if (r_stop_edge || w_expire) begin
          w_next     = S_IDLE;
          w_pass_n   = 4'd0;
          w_load     = 1'b1;
          w_load_val = '0;
        end else begin
          w_dec = tick;
        end
      end
      S_PAUSE: begin
        if (r_stop_edge || r_start_edge) begin
          w_next = r_saved;
        end
      end
      S_ERROR: begin
        if (r_stop_edge) begin
          w_next     = S_IDLE;
          w_pass_n   = 4'd0;
          w_load     = 1'b1;
          w_load_val = '0;
        end
      end
    endcase
  end

  assign fill_valve  = (r_state == S_FILL);
  assign motor       = (r_state == S_WASH) | (r_state == S_SPIN);
  assign drain_valve = (r_state == S_DRAIN) | (r_state == S_SPIN);
  assign alarm       = (r_state == S_DONE) | (r_state == S_ERROR);
  assign state       = r_state;
  assign pass_idx    = r_pass;
  assign time_bcd    = w_time;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with hand-computed expectations.
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic       stop;
  logic       waterfull;
  logic       fill_valve, motor, drain_valve, alarm;
  logic [2:0] state;
  logic [3:0] pass_idx;
  logic [7:0] time_bcd;

  logic       d2_fill, d2_motor, d2_drain, d2_alarm;
  logic [2:0] d2_state;
  logic [3:0] d2_pass;
  logic [7:0] d2_time;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wash_sequencer #(
    .WASH_SEC(3), .RINSE_SEC(2), .DRAIN_SEC(2), .SPIN_SEC(2),
    .ALARM_SEC(2), .RINSE_CNT(1), .TIME_DIGITS(2),
    .FILL_TIMEOUT_SEC(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .stop(stop), .waterfull(waterfull),
    .fill_valve(fill_valve), .motor(motor),
    .drain_valve(drain_valve), .alarm(alarm),
    .state(state), .pass_idx(pass_idx), .time_bcd(time_bcd)
  );

  wash_sequencer #(
    .WASH_SEC(12), .RINSE_SEC(2), .DRAIN_SEC(2), .SPIN_SEC(2),
    .ALARM_SEC(2), .RINSE_CNT(1), .TIME_DIGITS(2),
    .FILL_TIMEOUT_SEC(30)
  ) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .stop(stop), .waterfull(waterfull),
    .fill_valve(d2_fill), .motor(d2_motor),
    .drain_valve(d2_drain), .alarm(d2_alarm),
    .state(d2_state), .pass_idx(d2_pass), .time_bcd(d2_time)
  );

  function automatic logic [18:0] obs_vec();
    return {state, fill_valve, motor, drain_valve, alarm,
            pass_idx, time_bcd};
  endfunction

  function automatic logic [18:0] exp_vec(input logic [2:0] st,
                                          input logic [3:0] pi,
                                          input logic [7:0] tm);
    logic [3:0] o;
    case (st)
      3'd1:    o = 4'b1000;
      3'd2:    o = 4'b0100;
      3'd3:    o = 4'b0010;
      3'd4:    o = 4'b0110;
      3'd5:    o = 4'b0001;
      3'd7:    o = 4'b0001;
      default: o = 4'b0000;
    endcase
    return {st, o, pi, tm};
  endfunction

  task automatic chk(input string tag, input logic [18:0] o,
                     input logic [18:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] o,
                      input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, o, e);
    end
  endtask

  task automatic expect_st(input string tag, input logic [2:0] st,
                           input logic [3:0] pi, input logic [7:0] tm);
    chk(tag, obs_vec(), exp_vec(st, pi, tm));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic press(input logic s_start, input logic s_stop);
    start = s_start;
    stop  = s_stop;
    cyc();
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    cyc();
  endtask

  task automatic fill_wait_then_full();
    for (int i = 0; i < 4; i++) cyc();
    waterfull = 1'b1;
    cyc();
    waterfull = 1'b0;
  endtask

  task automatic run_phase(input string tag, input logic [2:0] st,
                           input logic [3:0] pi, input int n,
                           input logic [2:0] nst, input logic [3:0] npi,
                           input logic [7:0] ntm);
    for (int k = n; k >= 1; k--) begin
      expect_st(tag, st, pi, 8'(k));
      tick1();
    end
    expect_st({tag, "_exit"}, nst, npi, ntm);
  endtask

  logic [7:0] t5 [12];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    t5 = '{8'h12, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07,
           8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    reset = 1'b0; tick = 1'b0; start = 1'b0;
    stop = 1'b0; waterfull = 1'b0;
    #3;
    expect_st("reset", 3'd0, 4'd0, 8'h00);
    reset = 1'b1;
    cyc();

    // Idle ignores stop and waterfull.
    waterfull = 1'b1;
    press(1'b0, 1'b1);
    waterfull = 1'b0;
    expect_st("idle_stop", 3'd0, 4'd0, 8'h00);

    // Full cycle.
    press(1'b1, 1'b0);
    expect_st("fill0", 3'd1, 4'd0, 8'h00);
    tick1();
    expect_st("fill0_tick", 3'd1, 4'd0, 8'h00);
    fill_wait_then_full();
    run_phase("wash0", 3'd2, 4'd0, 3, 3'd3, 4'd0, 8'h02);
    run_phase("drain0", 3'd3, 4'd0, 2, 3'd1, 4'd1, 8'h00);
    fill_wait_then_full();
    run_phase("rinse1", 3'd2, 4'd1, 2, 3'd3, 4'd1, 8'h02);
    run_phase("drain1", 3'd3, 4'd1, 2, 3'd4, 4'd1, 8'h02);
    run_phase("spin", 3'd4, 4'd1, 2, 3'd5, 4'd1, 8'h02);
    run_phase("done", 3'd5, 4'd1, 2, 3'd0, 4'd0, 8'h00);

    // Pause and resume in wash; start ignored while running.
    press(1'b1, 1'b0);
    fill_wait_then_full();
    expect_st("t2_wash", 3'd2, 4'd0, 8'h03);
    tick1();
    press(1'b1, 1'b0);
    expect_st("t2_start_ign", 3'd2, 4'd0, 8'h02);
    press(1'b0, 1'b1);
    expect_st("t2_pause", 3'd6, 4'd0, 8'h02);
    tick1(); tick1(); tick1();
    expect_st("t2_frozen", 3'd6, 4'd0, 8'h02);
    press(1'b1, 1'b0);
    run_phase("t2_resume", 3'd2, 4'd0, 2, 3'd3, 4'd0, 8'h02);

    // Simultaneous edges in drain, then resume by stop.
    press(1'b1, 1'b1);
    expect_st("t3_both_drain", 3'd6, 4'd0, 8'h02);
    press(1'b0, 1'b1);
    run_phase("t3_drain", 3'd3, 4'd0, 2, 3'd1, 4'd1, 8'h00);
    fill_wait_then_full();
    run_phase("t4_rinse", 3'd2, 4'd1, 2, 3'd3, 4'd1, 8'h02);
    run_phase("t4_drain", 3'd3, 4'd1, 2, 3'd4, 4'd1, 8'h02);
    tick1();
    expect_st("t4_spin", 3'd4, 4'd1, 8'h01);

    // Asynchronous reset mid-spin, between clock edges.
    #3;
    reset = 1'b0;
    #1;
    expect_st("t4_async", 3'd0, 4'd0, 8'h00);
    #1;
    reset = 1'b1;
    cyc();
    expect_st("t4_after", 3'd0, 4'd0, 8'h00);

    press(1'b1, 1'b1);
    expect_st("t3_both_idle", 3'd0, 4'd0, 8'h00);

    // BCD borrow on a two-digit wash duration.
    press(1'b1, 1'b0);
    fill_wait_then_full();
    for (int i = 0; i < 12; i++) begin
      chk8("t5_bcd", d2_time, t5[i]);
      tick1();
    end
    chk8("t5_state", {5'd0, d2_state}, 8'd3);
    chk8("t5_time", d2_time, 8'h02);

    reset = 1'b0;
    #2;
    reset = 1'b1;
    cyc();
`ifdef WASH_FILL_TIMEOUT_EN
    press(1'b1, 1'b0);
    expect_st("t6_fill3", 3'd1, 4'd0, 8'h03);
    tick1();
    expect_st("t6_fill2", 3'd1, 4'd0, 8'h02);
    tick1();
    expect_st("t6_fill1", 3'd1, 4'd0, 8'h01);
    tick1();
    expect_st("t6_error", 3'd7, 4'd0, 8'h00);
    press(1'b1, 1'b0);
    expect_st("t6_start_ign", 3'd7, 4'd0, 8'h00);
    press(1'b0, 1'b1);
    expect_st("t6_clear", 3'd0, 4'd0, 8'h00);
`else
    press(1'b1, 1'b0);
    expect_st("t6_fill", 3'd1, 4'd0, 8'h00);
    tick1(); tick1(); tick1(); tick1();
    expect_st("t6_wait", 3'd1, 4'd0, 8'h00);
    press(1'b0, 1'b1);
    expect_st("t6_pause", 3'd6, 4'd0, 8'h00);
    press(1'b1, 1'b0);
    expect_st("t6_resume", 3'd1, 4'd0, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
